// File: rtl/uart_tx_sequencer_pkg.sv
// Shared types and constants for the UART transmit sequencer.
package uart_tx_pkg;

    // Frame sequencing states
    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        START,
        BUSY,
        GAP
    } state_t;

    localparam logic [1:0] PARITY_ODD = 2'b01;
    localparam logic [1:0] BAUD_9600  = 2'b10;

    // TxUnit line configuration
    typedef struct packed {
        logic [1:0] parity;
        logic [1:0] baud;
    } cfg_t;

    localparam cfg_t CFG_RESET = '{parity: PARITY_ODD, baud: BAUD_9600};

endpackage

// File: rtl/uart_tx_sequencer_if.sv
// Producer, config, TxUnit and status signals of the sequencer.
// master = sequencer side, slave = environment (producer / TxUnit / bench).
interface uart_tx_sequencer_if #(
    parameter int DEPTH = 16
);
    logic                     in_valid;
    logic [7:0]               in_data;
    logic                     in_ready;
    logic                     cfg_we;
    logic [1:0]               cfg_parity;
    logic [1:0]               cfg_baud;
    logic                     tx_send;
    logic [7:0]               tx_data;
    logic [1:0]               tx_parity_type;
    logic [1:0]               tx_baud_rate;
    logic                     tx_active_flag;
    logic                     tx_done_flag;
    logic [$clog2(DEPTH):0]   fifo_count;
    logic                     busy;
    logic                     err_timeout;

    modport master (
        input  in_valid, in_data, cfg_we, cfg_parity, cfg_baud,
               tx_active_flag, tx_done_flag,
        output in_ready, tx_send, tx_data, tx_parity_type, tx_baud_rate,
               fifo_count, busy, err_timeout
    );

    modport slave (
        output in_valid, in_data, cfg_we, cfg_parity, cfg_baud,
               tx_active_flag, tx_done_flag,
        input  in_ready, tx_send, tx_data, tx_parity_type, tx_baud_rate,
               fifo_count, busy, err_timeout
    );

endinterface

// File: rtl/uart_tx_sequencer_sync_fifo.sv
// Single-clock FIFO; pushes when full and pops when empty are ignored.
// Storage has no reset: resetting the pointers is what discards contents.
module sync_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   i_push,
    input  logic                   i_pop,
    input  logic [WIDTH-1:0]       i_data,
    output logic [WIDTH-1:0]       o_data,
    output logic                   o_full,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] P_ONE    = AW'(1);
    localparam logic [AW:0]   C_ONE    = (AW + 1)'(1);
    localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [AW:0]      r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_count == FULL_CNT);
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_data  = r_mem[r_rptr];
    assign w_push  = i_push & ~o_full;
    assign w_pop   = i_pop & ~o_empty;

    // Storage write
    always_ff @(posedge clock) begin
        if (w_push) r_mem[r_wptr] <= i_data;
    end

    // Pointers wrap naturally (DEPTH is a power of 2); count tracks occupancy
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + P_ONE;
            if (w_pop)  r_rptr <= r_rptr + P_ONE;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + C_ONE;
                2'b01:   r_count <= r_count - C_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_sequencer.sv
// Buffers producer bytes and hands them to TxUnit one frame at a time.
// Owns TxUnit's parity/baud config; updates land only between frames.
module uart_tx_sequencer
    import uart_tx_pkg::*;
#(
    parameter int DEPTH      = 16,
    parameter int GAP_CYCLES = 4,
    parameter int TIMEOUT    = 1024
) (
    input  logic                clock,
    input  logic                reset_n,
    uart_tx_sequencer_if.master bus
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int TW = $clog2(TIMEOUT);
    localparam int GW = $clog2(GAP_CYCLES + 1);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0] T_ONE  = TW'(1);
    localparam logic [GW-1:0] G_LAST = GW'(GAP_CYCLES - 1);
    localparam logic [GW-1:0] G_ONE  = GW'(1);

    state_t        r_state;
    logic          r_tx_send;
    logic [7:0]    r_tx_data;
    cfg_t          r_cfg_act;
    cfg_t          r_cfg_pend;
    logic [TW-1:0] r_timer;
    logic [GW-1:0] r_gap;
    logic          r_err;

    logic          w_push;
    logic          w_pop;
    logic          w_full;
    logic          w_empty;
    logic [7:0]    w_head;
    logic [CW-1:0] w_count;
    cfg_t          w_cfg_next;
    logic          w_cfg_ok;

    // in_ready comes from the registered count only; no full-FIFO bypass
    assign w_push = bus.in_valid & ~w_full;
    assign w_pop  = (r_state == LOAD);

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clock   (clock),
        .reset_n (reset_n),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  (bus.in_data),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    // A write arriving in the same cycle as an apply point is forwarded
    assign w_cfg_next = bus.cfg_we ? cfg_t'({bus.cfg_parity, bus.cfg_baud}) : r_cfg_pend;
    // Never touch the line config while TxUnit reports a frame in progress
    assign w_cfg_ok   = ~bus.tx_active_flag;

    // Pending config register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) r_cfg_pend <= CFG_RESET;
        else if (bus.cfg_we) r_cfg_pend <= w_cfg_next;
    end

    // Frame sequencer: state, handshake outputs, timeout, gap and config apply
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= IDLE;
            r_tx_send <= 1'b0;
            r_tx_data <= 8'h00;
            r_cfg_act <= CFG_RESET;
            r_timer   <= '0;
            r_gap     <= '0;
            r_err     <= 1'b0;
        end else begin
            // Clear first so a same-cycle abort below overrides it
            if (bus.cfg_we) r_err <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_cfg_ok) r_cfg_act <= w_cfg_next;
                    if (!w_empty) r_state <= LOAD;
                end
                LOAD: begin
                    r_tx_data <= w_head;
                    r_timer   <= '0;
                    r_tx_send <= 1'b1;
                    r_state   <= START;
                end
                START: begin
                    if (bus.tx_active_flag || bus.tx_done_flag) begin
                        // done seen here means TxUnit finished before we saw active
                        r_tx_send <= 1'b0;
                        r_gap     <= '0;
                        r_state   <= bus.tx_done_flag ? GAP : BUSY;
                    end else if (r_timer == T_LAST) begin
                        // TxUnit never took the byte: drop it and flag
                        r_tx_send <= 1'b0;
                        r_err     <= 1'b1;
                        r_gap     <= '0;
                        r_state   <= GAP;
                    end else begin
                        r_timer <= r_timer + T_ONE;
                    end
                end
                BUSY: begin
                    if (bus.tx_done_flag) begin
                        r_gap   <= '0;
                        r_state <= GAP;
                    end
                end
                GAP: begin
                    if (r_gap == G_LAST) begin
                        if (w_cfg_ok) r_cfg_act <= w_cfg_next;
                        r_state <= IDLE;
                    end else begin
                        r_gap <= r_gap + G_ONE;
                    end
                end
                default: begin
                    r_tx_send <= 1'b0;
                    r_state   <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready       = ~w_full;
    assign bus.tx_send        = r_tx_send;
    assign bus.tx_data        = r_tx_data;
    assign bus.tx_parity_type = r_cfg_act.parity;
    assign bus.tx_baud_rate   = r_cfg_act.baud;
    assign bus.fifo_count     = w_count;
    assign bus.busy           = (r_state != IDLE) | ~w_empty;
    assign bus.err_timeout    = r_err;

endmodule

// File: tb/tb_uart_tx_sequencer.sv
// Directed bench for uart_tx_sequencer with a small TxUnit responder model.
module tb_uart_tx_sequencer;
    import uart_tx_pkg::*;

    localparam int DEPTH = 16;
    localparam int GAP   = 4;
    localparam int TMO   = 1024;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    uart_tx_sequencer_if #(.DEPTH(DEPTH)) bus();

    uart_tx_sequencer #(
        .DEPTH      (DEPTH),
        .GAP_CYCLES (GAP),
        .TIMEOUT    (TMO)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [7:0] exp_q[$];
    bit model_en  = 1'b1;
    int frame_len = 8;
    int frames    = 0;
    int last_done = 0;
    bit have_done = 1'b0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Present one byte and hold it until accepted; record it as expected traffic
    task automatic push(input logic [7:0] b);
        int  n;
        bit  acc;
        n = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        forever begin
            acc = bus.in_ready;
            @(posedge clock); #1;
            if (acc) break;
            n++;
            if (n > 5000) begin
                check("push_timeout", {24'h0, b}, 32'hFFFF_FFFF);
                break;
            end
        end
        if (acc) exp_q.push_back(b);
        bus.in_valid = 1'b0;
    endtask

    // Wait for the sequencer to go fully idle, bounded
    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (bus.busy !== 1'b0 && n < 5000) begin
            @(posedge clock); #1;
            n++;
        end
        check(tag, bus.busy, 1'b0);
    endtask

    // TxUnit model: takes a frame on tx_send, reports active for frame_len clocks, pulses done
    initial begin
        int mst;
        int mcnt;
        mst  = 0;
        mcnt = 0;
        bus.tx_active_flag = 1'b0;
        bus.tx_done_flag   = 1'b0;
        forever begin
            @(posedge clock); #1;
            case (mst)
                0: if (model_en && bus.tx_send === 1'b1) begin
                    bus.tx_active_flag = 1'b1;
                    mcnt = 0;
                    mst  = 1;
                    frames++;
                    check("frame_expected", exp_q.size() != 0, 1'b1);
                    if (exp_q.size() != 0) check("frame_data", bus.tx_data, exp_q.pop_front());
                    if (have_done) check("frame_gap", (cyc - last_done - 1) >= GAP, 1'b1);
                end
                1: begin
                    mcnt++;
                    if (mcnt >= frame_len) begin
                        bus.tx_active_flag = 1'b0;
                        bus.tx_done_flag   = 1'b1;
                        last_done = cyc;
                        have_done = 1'b1;
                        mst = 2;
                    end
                end
                default: begin
                    bus.tx_done_flag = 1'b0;
                    mst = 0;
                end
            endcase
        end
    end

    initial begin
        int n;
        int f0;
        bit seen;
        bus.in_valid   = 1'b0;
        bus.in_data    = 8'h00;
        bus.cfg_we     = 1'b0;
        bus.cfg_parity = PARITY_ODD;
        bus.cfg_baud   = BAUD_9600;

        // ---- reset state
        repeat (3) @(posedge clock);
        #1 reset_n = 1'b1;
        @(posedge clock); #1;
        check("rst_tx_send",  bus.tx_send, 1'b0);
        check("rst_tx_data",  bus.tx_data, 8'h00);
        check("rst_parity",   bus.tx_parity_type, 2'b01);
        check("rst_baud",     bus.tx_baud_rate, 2'b10);
        check("rst_in_ready", bus.in_ready, 1'b1);
        check("rst_count",    bus.fifo_count, 5'd0);
        check("rst_busy",     bus.busy, 1'b0);
        check("rst_err",      bus.err_timeout, 1'b0);

        // ---- single byte: send 3 clocks after in_valid, drops after active
        push(8'h54);
        check("s1_send_c1", bus.tx_send, 1'b0);
        @(posedge clock); #1;
        check("s1_send_c2", bus.tx_send, 1'b0);
        @(posedge clock); #1;
        check("s1_send_c3", bus.tx_send, 1'b1);
        check("s1_data",    bus.tx_data, 8'h54);
        @(posedge clock); #1;
        check("s1_send_drop", bus.tx_send, 1'b0);
        wait_idle("s1_idle");
        check("s1_idle_after_gap", cyc - last_done, GAP + 1);

        // ---- push and pop in the same cycle at count 1
        push(8'hC1);
        @(posedge clock); #1;
        check("pp_count_before", bus.fifo_count, 5'd1);
        push(8'hC2);
        check("pp_count_same", bus.fifo_count, 5'd1);
        check("pp_send",       bus.tx_send, 1'b1);
        check("pp_data",       bus.tx_data, 8'hC1);
        wait_idle("pp_idle");

        // ---- fill FIFO while TxUnit holds a long frame
        frame_len = 60;
        f0 = frames;
        push(8'h80);
        n = 0;
        while (bus.tx_active_flag !== 1'b1 && n < 100) begin
            @(posedge clock); #1;
            n++;
        end
        for (int i = 0; i < 16; i++) push(8'h90 + 8'(i));
        check("full_count", bus.fifo_count, 5'd16);
        check("full_ready", bus.in_ready, 1'b0);
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hA0;
        repeat (3) @(posedge clock);
        #1;
        check("full_held_count", bus.fifo_count, 5'd16);
        check("full_held_ready", bus.in_ready, 1'b0);
        push(8'hA0);
        frame_len = 6;
        wait_idle("full_idle");
        check("full_frames", frames - f0, 18);
        check("full_drained", exp_q.size(), 0);

        // ---- timeout: TxUnit silent; cfg_we lands on the abort edge
        model_en = 1'b0;
        push(8'hA5);
        push(8'h3C);
        n = 0;
        while (bus.tx_send !== 1'b1 && n < 100) begin
            @(posedge clock); #1;
            n++;
        end
        n = 0;
        while (bus.tx_send === 1'b1 && n < 3000) begin
            n++;
            bus.cfg_we = (n == TMO);
            @(posedge clock); #1;
        end
        bus.cfg_we = 1'b0;
        check("tmo_len",      n, TMO);
        check("tmo_send_low", bus.tx_send, 1'b0);
        check("tmo_err_set_wins", bus.err_timeout, 1'b1);
        void'(exp_q.pop_front());
        model_en = 1'b1;
        wait_idle("tmo_idle");
        check("tmo_err_sticky", bus.err_timeout, 1'b1);
        bus.cfg_we = 1'b1;
        @(posedge clock); #1;
        bus.cfg_we = 1'b0;
        check("tmo_err_clear", bus.err_timeout, 1'b0);

        // ---- config write during BUSY applies only between frames
        frame_len = 20;
        push(8'h11);
        n = 0;
        while (bus.tx_active_flag !== 1'b1 && n < 100) begin
            @(posedge clock); #1;
            n++;
        end
        bus.cfg_parity = 2'b10;
        bus.cfg_baud   = 2'b01;
        bus.cfg_we     = 1'b1;
        @(posedge clock); #1;
        bus.cfg_we = 1'b0;
        push(8'h22);
        repeat (3) @(posedge clock);
        #1;
        check("cfg_busy_parity", bus.tx_parity_type, 2'b01);
        check("cfg_busy_baud",   bus.tx_baud_rate, 2'b10);
        n = 0;
        while (bus.tx_send !== 1'b1 && n < 200) begin
            @(posedge clock); #1;
            n++;
        end
        check("cfg_next_send",   bus.tx_send, 1'b1);
        check("cfg_next_parity", bus.tx_parity_type, 2'b10);
        check("cfg_next_baud",   bus.tx_baud_rate, 2'b01);
        wait_idle("cfg_idle");

        // ---- reset mid-frame with 5 bytes queued
        frame_len = 50;
        for (int i = 0; i < 6; i++) push(8'h61 + 8'(i));
        check("mr_count_before", bus.fifo_count, 5'd5);
        check("mr_busy_before",  bus.busy, 1'b1);
        #2 reset_n = 1'b0;
        #1;
        check("mr_send",   bus.tx_send, 1'b0);
        check("mr_count",  bus.fifo_count, 5'd0);
        check("mr_busy",   bus.busy, 1'b0);
        check("mr_parity", bus.tx_parity_type, 2'b01);
        check("mr_baud",   bus.tx_baud_rate, 2'b10);
        exp_q.delete();
        @(posedge clock); #1;
        reset_n = 1'b1;
        f0   = frames;
        seen = 1'b0;
        repeat (100) begin
            @(posedge clock); #1;
            seen = seen | (bus.tx_send === 1'b1);
        end
        check("mr_no_send",   seen, 1'b0);
        check("mr_no_frames", frames - f0, 0);
        check("mr_idle",      bus.busy, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
